// File: rtl/neuron_pkg.sv
// Shared arithmetic helpers for the fully-connected layer blocks:
// width math, saturation, round-shift and the accumulator width check.
package neuron_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // The accumulator must hold a full beat sum without wrapping.
    function automatic bit acc_width_ok(input int dw, input int lanes, input int accw);
        return accw >= 2 * dw + clog2(lanes);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v)
            return max_v;
        else if (value < min_v)
            return min_v;
        else
            return value;
    endfunction

    // Round half up, then floor via arithmetic shift.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] value,
                                                       input int shift);
        if (shift > 0)
            return (value + (64'sd1 <<< (shift - 1))) >>> shift;
        else
            return value;
    endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Combinational signed reduction of the lane products, pairwise per level
// so the depth grows with clog2(LANES) rather than LANES.
module mac_adder_tree
    import neuron_pkg::*;
#(
    parameter int LANES = 20,
    parameter int IW    = 16
) (
    input  logic [LANES*IW-1:0]             products,
    output logic [IW+clog2(LANES)-1:0]      sum
);

    localparam int LEVELS = clog2(LANES);
    localparam int OW     = IW + LEVELS;
    localparam int PAD    = 1 << LEVELS;

    logic signed [OW-1:0] vals [PAD];

    // In-place reduction: each level reads indices >= the one it writes.
    always_comb begin
        for (int j = 0; j < PAD; j++) begin
            vals[j] = '0;
        end
        for (int j = 0; j < LANES; j++) begin
            vals[j] = OW'($signed(products[j*IW +: IW]));
        end
        for (int lv = 1; lv <= LEVELS; lv++) begin
            for (int j = 0; j < (PAD >> lv); j++) begin
                vals[j] = vals[2*j] + vals[2*j+1];
            end
        end
        sum = vals[0];
    end

endmodule

// File: rtl/neuron_mac_array.sv
// Three-stage multi-lane neuron accumulator: multiply, adder-tree reduce,
// then accumulate/requantise with a valid/ready result port.
module neuron_mac_array
    import neuron_pkg::*;
#(
    parameter int LANES = 20,
    parameter int DW    = 8,
    parameter int ACCW  = 24,
    parameter int SHIFT = 4,
    parameter int OUTW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic                  in_bias,
    input  logic                  relu_en,
    input  logic [LANES*DW-1:0]   in_data,
    input  logic [LANES*DW-1:0]   in_weight,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUTW-1:0]       out_data,
    output logic                  out_ovf
);

    localparam int PW = 2 * DW;
    localparam int SW = PW + clog2(LANES);

    generate
        if (!acc_width_ok(DW, LANES, ACCW)) begin : g_bad_accw
            $error("neuron_mac_array: ACCW too narrow for DW and LANES");
        end
    endgenerate

    logic                    adv;
    logic signed [DW-1:0]    lane_d;
    logic signed [DW-1:0]    lane_w;
    logic [LANES*PW-1:0]     prod_next;

    logic                    s1_valid, s1_first, s1_last, s1_relu;
    logic [LANES*PW-1:0]     s1_prod;
    logic [SW-1:0]           tree_sum;

    logic                    s2_valid, s2_first, s2_last, s2_relu;
    logic signed [SW-1:0]    s2_sum;

    logic signed [ACCW-1:0]  acc;
    logic                    ovf;
    logic signed [ACCW-1:0]  sum_ext;
    logic signed [ACCW-1:0]  acc_base;
    logic signed [63:0]      acc_wide;
    logic signed [63:0]      acc_sat;
    logic signed [ACCW-1:0]  acc_next;
    logic                    ovf_next;
    logic signed [OUTW-1:0]  quant;
    logic [OUTW-1:0]         result;

    // A pending result that nobody takes freezes the whole pipeline.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    // Bias beats keep only the lane 0 product.
    always_comb begin
        prod_next = '0;
        lane_d    = '0;
        lane_w    = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_d = in_data[i*DW +: DW];
            lane_w = in_weight[i*DW +: DW];
            if (!(in_bias && i != 0))
                prod_next[i*PW +: PW] = PW'(lane_d) * PW'(lane_w);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_relu  <= 1'b0;
            s1_prod  <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_first <= in_first;
            s1_last  <= in_last;
            s1_relu  <= relu_en;
            s1_prod  <= prod_next;
        end
    end

    mac_adder_tree #(
        .LANES (LANES),
        .IW    (PW)
    ) u_tree (
        .products (s1_prod),
        .sum      (tree_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_relu  <= 1'b0;
            s2_sum   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_relu  <= s1_relu;
            s2_sum   <= tree_sum;
        end
    end

    // Saturating accumulate and output requantisation.
    always_comb begin
        sum_ext  = ACCW'(s2_sum);
        acc_base = s2_first ? '0 : acc;
        acc_wide = 64'(acc_base) + 64'(sum_ext);
        acc_sat  = saturate(acc_wide, ACCW);
        acc_next = acc_sat[ACCW-1:0];
        ovf_next = (!s2_first && ovf) || (acc_sat != acc_wide);
        quant    = OUTW'(saturate(round_shift(64'(acc_next), SHIFT), OUTW));
        result   = (s2_relu && quant[OUTW-1]) ? '0 : quant;
    end

    // With adv high, a standing out_valid implies out_ready, so it is consumed here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            if (s2_valid) begin
                acc <= acc_next;
                ovf <= ovf_next;
            end
            if (s2_valid && s2_last) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_ovf   <= ovf_next;
            end else if (out_valid) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_array.sv
// Directed bench for neuron_mac_array: hand-computed results for single,
// multi-beat, bias, ReLU, saturation, stall and reset scenarios.
module tb_neuron_mac_array;

    localparam int LANES = 20;
    localparam int DW    = 8;
    localparam int ACCW  = 24;
    localparam int SHIFT = 4;
    localparam int OUTW  = 8;

    logic                        clk;
    logic                        rst;
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_first;
    logic                        in_last;
    logic                        in_bias;
    logic                        relu_en;
    logic [LANES*DW-1:0]         in_data;
    logic [LANES*DW-1:0]         in_weight;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUTW-1:0]      out_data;
    logic                        out_ovf;

    int checks;
    int failures;
    int data_q[$];
    int ovf_q[$];

    neuron_mac_array #(
        .LANES (LANES),
        .DW    (DW),
        .ACCW  (ACCW),
        .SHIFT (SHIFT),
        .OUTW  (OUTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_bias   (in_bias),
        .relu_en   (relu_en),
        .in_data   (in_data),
        .in_weight (in_weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes complete on the following rising edge; inputs only move just after rising edges.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            data_q.push_back(int'(out_data));
            ovf_q.push_back(int'(out_ovf));
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks = checks + 1;
        if (observed !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic first, input logic last, input logic bias,
                                 input logic relu, input logic signed [DW-1:0] d_all,
                                 input logic signed [DW-1:0] w_all,
                                 input logic signed [DW-1:0] d_lane0,
                                 input logic signed [DW-1:0] w_lane0);
        int waited;
        for (int i = 0; i < LANES; i++) begin
            in_data[i*DW +: DW]   = (i == 0) ? d_lane0 : d_all;
            in_weight[i*DW +: DW] = (i == 0) ? w_lane0 : w_all;
        end
        in_first = first;
        in_last  = last;
        in_bias  = bias;
        relu_en  = relu;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50)
            checkOutput("in_ready_timeout", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expectResult(input string tag, input int exp_data, input int exp_ovf);
        int waited;
        int got_d;
        int got_o;
        waited = 0;
        while (data_q.size() == 0 && waited < 30) begin
            tick();
            waited++;
        end
        if (data_q.size() == 0) begin
            checkOutput({tag, "_timeout"}, data_q.size(), 1);
        end else begin
            got_d = data_q.pop_front();
            got_o = ovf_q.pop_front();
            checkOutput({tag, "_data"}, got_d, exp_data);
            checkOutput({tag, "_ovf"}, got_o, exp_ovf);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_bias   = 1'b0;
        relu_en   = 1'b0;
        in_data   = '0;
        in_weight = '0;
        out_ready = 1'b1;
        repeat (3) tick();

        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_out_ovf", int'(out_ovf), 0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        tick();

        // 20 lanes of 16*1 = 320 -> (320+8)>>4 = 20, visible after the second edge.
        applyStimulus(1, 1, 0, 0, 16, 1, 16, 1);
        checkOutput("lat_e0", int'(out_valid), 0);
        tick();
        checkOutput("lat_e1", int'(out_valid), 0);
        tick();
        checkOutput("lat_e2", int'(out_valid), 1);
        expectResult("single", 20, 0);

        // Bias 100*2 = 200 (other lanes ignored), then 20*15 = 300 -> 500 -> 31.
        applyStimulus(1, 0, 1, 0, 7, 7, 100, 2);
        applyStimulus(0, 1, 0, 0, 3, 5, 3, 5);
        expectResult("bias", 31, 0);

        // -320 -> (-312)>>>4 = -20; ReLU clamps to 0.
        applyStimulus(1, 1, 0, 0, -1, 16, -1, 16);
        expectResult("neg", -20, 0);
        applyStimulus(1, 1, 0, 1, -1, 16, -1, 16);
        expectResult("relu", 0, 0);

        // 20*16129 = 322580 -> 20161 -> clamps to 127.
        applyStimulus(1, 1, 0, 0, 127, 127, 127, 127);
        expectResult("out_sat", 127, 0);

        // 40 beats of 322580 overflow the 24-bit accumulator at beat 27.
        for (int b = 1; b <= 40; b++)
            applyStimulus(b == 1, b == 40, 0, 0, 127, 127, 127, 127);
        expectResult("acc_sat", 127, 1);
        checkOutput("acc_clamp_value", int'(dut.acc), 8388607);
        applyStimulus(1, 1, 0, 0, 16, 1, 16, 1);
        expectResult("after_sat", 20, 0);

        // Back-to-back neurons with the consumer stalled.
        checkOutput("b2b_q_empty", data_q.size(), 0);
        out_ready = 1'b0;
        applyStimulus(1, 1, 0, 0, 16, 1, 16, 1);
        applyStimulus(1, 1, 0, 0, -1, 16, -1, 16);
        tick();
        for (int h = 0; h < 5; h++) begin
            checkOutput("hold_valid", int'(out_valid), 1);
            checkOutput("hold_data", int'(out_data), 20);
            checkOutput("hold_in_ready", int'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        expectResult("b2b_a", 20, 0);
        expectResult("b2b_b", -20, 0);
        repeat (5) tick();
        checkOutput("b2b_no_dup", data_q.size(), 0);
        checkOutput("b2b_idle", int'(out_valid), 0);

        // Reset between the first and last beats discards the partial neuron.
        applyStimulus(1, 0, 0, 0, 127, 127, 127, 127);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        checkOutput("rst_mid_no_out", data_q.size(), 0);
        checkOutput("rst_mid_valid", int'(out_valid), 0);
        applyStimulus(0, 1, 0, 0, 16, 1, 16, 1);
        expectResult("after_rst", 20, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_mac_array.md
# neuron_mac_array

Parametrised, pipelined multi-lane neuron accumulator for the fully-connected stages of the texture-classification network on the FPGA. Each accepted beat multiplies LANES signed input/weight pairs, reduces them through an adder tree and accumulates across beats until a `last` beat closes the neuron. The closed neuron is bias-corrected, rounded, re-quantised, saturated and optionally ReLU-clamped, then presented on a valid/ready output. Upstream are the feature/weight buffer readers; downstream is the layer output buffer.

## Interface
- LANES, 20, multiply lanes per beat (≥1)
- DW, 8, signed data and weight width
- ACCW, 24, signed accumulator width; must be ≥ 2*DW + clog2(LANES)
- SHIFT, 4, fixed-point right shift applied at output (0 allowed)
- OUTW, 8, signed output width
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_first  in  1  beat opens a neuron: accumulator loads instead of adding
- in_last  in  1  beat closes a neuron: result produced
- in_bias  in  1  bias beat: only lane 0 product counts, lanes 1..LANES-1 forced to 0
- relu_en  in  1  ReLU mode, sampled with the last beat
- in_data  in  LANES*DW  lane i at [i*DW +: DW], signed
- in_weight  in  LANES*DW  lane i at [i*DW +: DW], signed
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  OUTW  quantised neuron result, signed
- out_ovf  out  1  accumulator saturated at some point during this neuron

## Operation
- Global advance enable `adv = !(out_valid && !out_ready)`; in_ready = adv (combinational). When adv=0 every pipeline register holds.
- S1: register LANES products (2*DW signed), plus the valid, first, last and relu flags.
- S2: adder tree sums the S1 products into 2*DW+clog2(LANES) bits; the sum is registered with the flags.
- S3: sign-extend the sum to ACCW.
  - If first: acc = sum. Otherwise: acc = acc + sum, saturated to ACCW signed range.
  - ovf flag: set on saturation; cleared by first (first beat's own saturation still sets it).
  - If last: out_data = sat_OUTW((acc_next + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT); rounding addition is done at ACCW+1 bits; >>> is arithmetic (floor).
  - Then if relu_en and the result is negative, out_data = 0. out_ovf = ovf_next; out_valid set.
- out_valid clears on handshake unless a new result is written at the same edge (new result wins).
- first && last on one beat is a legal single-beat neuron. Beats without a preceding first after reset accumulate onto 0.
- Back-to-back neurons: the first beat of the next neuron may directly follow the last beat of the previous one. Flags travel with the data, so no bubble is required.

## Timing
- Reset: out_valid=0, out_data=0, out_ovf=0, acc=0, all stage valids=0; in_ready=1.
- Last beat accepted at edge E with no stall: out_valid=1 after edge E+2 (latency 3 cycles). Each stalled cycle adds one.
- Throughput: one beat per cycle while out_ready is high or out_valid is low.
- in_valid=0 inserts a bubble; the accumulator is untouched by invalid stage entries.
- rst asserted mid-neuron: in-flight beats and the partial accumulation are discarded immediately, with no output.

## Structure
- Package neuron_pkg: clog2 function, saturate and round-shift functions, and the ACCW ≥ 2*DW+clog2(LANES) check constant, shared with the other layer blocks.
- Sub-module mac_adder_tree (parameters LANES, IW): combinational signed reduction of the S1 products.

## Test plan
- LANES=20, SHIFT=4, single beat first+last, all data=16, weights=1 -> sum 320, out_data=20, out_ovf=0, out_valid 3 cycles after acceptance.
- Bias beat (lane0 data=100, weight=2, first) then data beat (all 3×5, last) -> acc 500, out_data=31.
- All lanes data=-1, weight=16, single beat -> out_data=-20 (0xEC) with relu_en=0, 0 with relu_en=1; 127×127 on all lanes -> out_data=127 (output saturation).
- 40 beats of 127×127 per lane (first on beat 1, last on beat 40) -> acc clamps at 8388607, out_ovf=1, out_data=127; the next neuron reports out_ovf=0.
- Two back-to-back single-beat neurons with out_ready low for 5 cycles -> first result held stable, in_ready=0 during the hold, both results delivered in order, no loss or duplication.
- rst pulse between first and last beats -> no output; the following neuron's result is correct.
